// File: rtl/mem_pkg.sv
// Shared widths and FSM encoding for the memory read-side unpacker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    localparam int ADDR_W         = 16;
    localparam int WORD_W         = 64;
    localparam int BYTE_W         = 8;
    localparam int CNT_W          = 16;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        STREAM,
        DONE
    } unpack_state_t;

    // Byte-index width; a one-byte word still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Word-to-byte serializer: shift register plus one-word hold, MSB byte first.
// Latency: a loaded word presents its first byte the cycle after load (when shift is free).
// Backpressure: out_data/out_valid hold while out_ready is low; shift advances only on accept.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   load_vld, load_dat  word capture strobe and data (goes to shift if free, else hold)
//   out_data/out_valid/out_ready  byte stream handshake
//   hold_full           hold register occupied
//   drain               accepting the final byte with nothing queued behind it
module byte_serializer #(
    parameter int WORD_W = mem_pkg::WORD_W,
    parameter int BYTE_W = mem_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_vld,
    input  logic [WORD_W-1:0] load_dat,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              hold_full,
    output logic              drain
);
    import mem_pkg::*;

    localparam int BPW   = WORD_W / BYTE_W;
    localparam int IDX_W = idx_width(BPW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] hold_q;
    logic              shift_vld_q;
    logic              hold_vld_q;
    logic [IDX_W-1:0]  idx_q;
    logic              accept;
    logic              last_byte;
    logic              shift_free;

    assign accept    = shift_vld_q & out_ready;
    assign last_byte = (idx_q == LAST_IDX);
    assign drain     = accept & last_byte & ~hold_vld_q;
    // Shift register has nothing left to show after this cycle's accept.
    assign shift_free = ~shift_vld_q | drain;

    assign out_valid = shift_vld_q;
    assign out_data  = shift_q[WORD_W-1 -: BYTE_W];
    assign hold_full = hold_vld_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q     <= '0;
            hold_q      <= '0;
            shift_vld_q <= 1'b0;
            hold_vld_q  <= 1'b0;
            idx_q       <= '0;
        end else begin
            if (accept) begin
                if (!last_byte) begin
                    shift_q <= shift_q << BYTE_W;
                    idx_q   <= idx_q + IDX_W'(1);
                end else if (hold_vld_q) begin
                    // Gapless hand-over: next word moves in on the last accept.
                    shift_q    <= hold_q;
                    idx_q      <= '0;
                    hold_vld_q <= 1'b0;
                end else begin
                    shift_vld_q <= 1'b0;
                    idx_q       <= '0;
                end
            end
            // Placed after the accept logic so a same-cycle capture overrides it.
            if (load_vld) begin
                if (shift_free) begin
                    shift_q     <= load_dat;
                    shift_vld_q <= 1'b1;
                    idx_q       <= '0;
                end else begin
                    hold_q     <= load_dat;
                    hold_vld_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/memory_unpacker.sv
// Streams a run of memory words from base_addr out as bytes, MSB first.
// Latency: start at t -> rd_ptr=base at t+1 -> first out_valid at t+3; done 1 cycle after last accept.
// Backpressure: out_valid/out_data held while out_ready low; reads pause while hold is full.
//
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   start                run request, sampled only in IDLE
//   base_addr, word_cnt  run description, latched on start
//   rd_ptr, rd_data      memory read port (data one cycle after pointer)
//   out_data/out_valid/out_ready  byte stream
//   busy, done           run in progress / one-cycle completion pulse
module memory_unpacker #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int WORD_W = mem_pkg::WORD_W,
    parameter int BYTE_W = mem_pkg::BYTE_W,
    parameter int CNT_W  = mem_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    output logic [ADDR_W-1:0] rd_ptr,
    input  logic [WORD_W-1:0] rd_data,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    import mem_pkg::*;

    unpack_state_t    state;
    logic [CNT_W-1:0] words_left;   // words not yet requested from memory
    logic             load_vld;
    logic             hold_full;
    logic             drain;

    // The single read in flight lands while in WAIT.
    assign load_vld = (state == WAIT);

    byte_serializer #(
        .WORD_W (WORD_W),
        .BYTE_W (BYTE_W)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load_vld  (load_vld),
        .load_dat  (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hold_full (hold_full),
        .drain     (drain)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            words_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_cnt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            rd_ptr     <= base_addr;
                            words_left <= word_cnt;
                            busy       <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // Pointer is already on the bus this cycle; advance for the next read.
                    rd_ptr     <= rd_ptr + ADDR_W'(1);
                    words_left <= words_left - CNT_W'(1);
                    state      <= WAIT;
                end
                WAIT: begin
                    state <= STREAM;
                end
                STREAM: begin
                    // Prefetch only into an empty hold so capacity is never exceeded.
                    if (words_left != '0 && !hold_full) begin
                        state <= FETCH;
                    end else if (words_left == '0 && drain) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_unpacker.sv
// Bench for memory_unpacker: memory model, byte-queue scoreboard, directed runs.
// Latency: n/a.
// Backpressure: out_ready driven constant or toggling per test.
module tb_memory_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_cnt;
    logic [15:0] rd_ptr;
    logic [63:0] rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    memory_unpacker #(
        .ADDR_W (16),
        .WORD_W (64),
        .BYTE_W (8),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .rd_ptr    (rd_ptr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    logic [63:0] mem [0:65535];
    always @(posedge clk) rd_data <= mem[rd_ptr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    bit toggle_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a run is the bytes of consecutive words, most significant byte first.
    task automatic expect_run(input logic [15:0] base, input int cnt);
        for (int w = 0; w < cnt; w++) begin
            logic [15:0] a;
            logic [63:0] word;
            a    = base + 16'(w);
            word = mem[a];
            for (int k = 0; k < 8; k++) exp_q.push_back(8'(word >> (8 * (7 - k))));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic wait_done(input string name, input int budget, output int when);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        check(name, 64'(done), 64'd1);
        when = cyc;
    endtask

    task automatic launch(input logic [15:0] base, input logic [15:0] cnt, output int t0);
        t0        = cyc;
        start     = 1'b1;
        base_addr = base;
        word_cnt  = cnt;
        expect_run(base, int'(cnt));
        tick;
        start = 1'b0;
    endtask

    // Scoreboard: every accepted byte against the model, plus hold stability.
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_stable", {55'd0, out_valid, out_data}, {55'd0, 1'b1, prev_data});
            if (out_valid && out_ready) begin
                check("byte_available", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("byte_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
            if (done) check("done_queue_empty", 64'(exp_q.size()), 64'd0);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (toggle_ready) out_ready = ~out_ready;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int w;
        int gaps;
        int dones;

        reset     = 1'b0;
        start     = 1'b0;
        base_addr = 16'h0;
        word_cnt  = 16'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 65536; i++)
            mem[i] = {16'(i), ~16'(i), 16'(i) ^ 16'h5A5A, 16'hC3C3};
        mem[4]        = 64'h0102030405060708;
        mem[10]       = 64'hA0A1A2A3A4A5A6A7;
        mem[11]       = 64'hB0B1B2B3B4B5B6B7;
        mem[12]       = 64'hC0C1C2C3C4C5C6C7;
        mem[20]       = 64'h1122334455667788;
        mem[16'hFFFF] = 64'hDEADBEEF01234567;
        mem[0]        = 64'h89ABCDEF76543210;
        mem[30]       = 64'h3031323334353637;
        mem[40]       = 64'hEEEEEEEEEEEEEEEE;
        mem[41]       = 64'hEEEEEEEEEEEEEEEE;
        mem[50]       = 64'h5051525354555657;
        mem[51]       = 64'h58595A5B5C5D5E5F;
        mem[60]       = 64'h6061626364656667;

        // Reset state
        repeat (3) tick;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_ptr", 64'(rd_ptr), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        tick;
        reset = 1'b1;
        tick;

        // 1: single word, exact latency
        launch(16'd4, 16'd1, t0);
        at_cycle(t0 + 1);
        check("t1_rd_ptr", 64'(rd_ptr), 64'd4);
        check("t1_busy", 64'(busy), 64'd1);
        at_cycle(t0 + 2);
        check("t1_no_early_valid", 64'(out_valid), 64'd0);
        for (int k = 0; k < 8; k++) begin
            at_cycle(t0 + 3 + k);
            check("t1_valid", 64'(out_valid), 64'd1);
            check("t1_byte", 64'(out_data), 64'(k + 1));
        end
        at_cycle(t0 + 11);
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy_off", 64'(busy), 64'd0);
        at_cycle(t0 + 12);
        check("t1_done_pulse", 64'(done), 64'd0);
        tick;

        // 2: three words, gapless
        launch(16'd10, 16'd3, t0);
        gaps = 0;
        for (int i = 0; i < 24; i++) begin
            at_cycle(t0 + 3 + i);
            if (!out_valid) gaps++;
            if (i == 0) check("t2_first_byte", 64'(out_data), 64'hA0);
            if (i == 8) check("t2_word1_byte0", 64'(out_data), 64'hB0);
        end
        check("t2_gaps", 64'(gaps), 64'd0);
        check("t2_last_byte", 64'(out_data), 64'hC7);
        at_cycle(t0 + 27);
        check("t2_done", 64'(done), 64'd1);
        tick;

        // 3: ready toggling 0,1,0,1...
        t0 = cyc;
        out_ready    = 1'b0;
        toggle_ready = 1'b1;
        launch(16'd20, 16'd1, t0);
        wait_done("t3_done", 100, w);
        check("t3_done_cycle", 64'(w), 64'(t0 + 19));
        check("t3_no_loss", 64'(exp_q.size()), 64'd0);
        toggle_ready = 1'b0;
        out_ready    = 1'b1;
        tick;

        // 4: address wrap
        launch(16'hFFFF, 16'd2, t0);
        at_cycle(t0 + 1);
        check("t4_rd_ptr_top", 64'(rd_ptr), 64'hFFFF);
        at_cycle(t0 + 3);
        check("t4_first_byte", 64'(out_data), 64'hDE);
        at_cycle(t0 + 4);
        check("t4_rd_ptr_wrap", 64'(rd_ptr), 64'h0000);
        at_cycle(t0 + 11);
        check("t4_second_word", 64'(out_data), 64'h89);
        at_cycle(t0 + 19);
        check("t4_done", 64'(done), 64'd1);
        tick;

        // 5a: empty run
        launch(16'h1234, 16'd0, t0);
        at_cycle(t0 + 1);
        check("t5_done", 64'(done), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_rd_ptr", 64'(rd_ptr), 64'h0001);
        at_cycle(t0 + 2);
        check("t5_done_pulse", 64'(done), 64'd0);
        tick;

        // 5b: start while busy is ignored
        launch(16'd30, 16'd1, t0);
        at_cycle(t0 + 2);
        tick;
        start     = 1'b1;
        base_addr = 16'd40;
        word_cnt  = 16'd2;
        tick;
        start = 1'b0;
        at_cycle(t0 + 11);
        check("t5b_done", 64'(done), 64'd1);
        at_cycle(t0 + 14);
        check("t5b_idle_busy", 64'(busy), 64'd0);
        check("t5b_idle_valid", 64'(out_valid), 64'd0);
        check("t5b_rd_ptr", 64'(rd_ptr), 64'd31);
        tick;

        // 6: reset mid-run after byte 3
        launch(16'd50, 16'd2, t0);
        at_cycle(t0 + 6);
        check("t6_byte3", 64'(out_data), 64'h53);
        tick;
        reset = 1'b0;
        exp_q.delete();
        tick;
        reset = 1'b1;
        at_cycle(t0 + 8);
        check("t6_valid_off", 64'(out_valid), 64'd0);
        check("t6_busy_off", 64'(busy), 64'd0);
        check("t6_rd_ptr", 64'(rd_ptr), 64'd0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            at_cycle(t0 + 9 + i);
        end
        check("t6_no_done", 64'(dones), 64'd0);
        tick;
        launch(16'd60, 16'd1, t0);
        at_cycle(t0 + 1);
        check("t6_new_rd_ptr", 64'(rd_ptr), 64'd60);
        at_cycle(t0 + 3);
        check("t6_new_first", 64'(out_data), 64'h60);
        at_cycle(t0 + 11);
        check("t6_new_done", 64'(done), 64'd1);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
